hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives the write enables and flushes of the pc register and the if_id, id_ex, ex_mem and mem_wb pipeline registers.
- Resolves three hazards:
  - load-use data hazards, with a 1-cycle bubble;
  - taken branches/jumps resolved in EX, by flushing the two younger stages;
  - multi-cycle data-memory accesses, using a req/ready handshake with timeout.
- Sits beside the datapath; the pipeline registers consume its wr/flush outputs.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_ctrl_if.sv | 40 ++++
 rtl/hz_wait_timer.sv | 30 +++
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer (hazard_ctrl).
// The optional HAZARD_PERF_EN build adds stall and flush counters to hazard_ctrl.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hz_state_t;

  localparam int DEF_REG_AW = 5;
  localparam int REG_ZERO   = 0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath-side bundle for hazard_ctrl: hazard sources in, pipeline enables and flushes out.
// The datapath drives the master modport; hazard_ctrl uses the slave modport.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              ex_branch_taken;
  logic              mem_req;
  logic              mem_ready;
  logic              pc_wr;
  logic              if_id_wr;
  logic              if_id_flush;
  logic              id_ex_wr;
  logic              id_ex_flush;
  logic              ex_mem_wr;
  logic              mem_wb_flush;
  logic              mem_timeout;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_wr, if_id_wr, if_id_flush, id_ex_wr, id_ex_flush, ex_mem_wr,
           mem_wb_flush, mem_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    output pc_wr, if_id_wr, if_id_flush, id_ex_wr, id_ex_flush, ex_mem_wr,
           mem_wb_flush, mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/hz_wait_timer.sv
// Saturating wait counter for memory stalls: load starts a wait at 1, en counts up,
// expired flags that MAX_WAIT cycles have been spent waiting.
module hz_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(MAX_WAIT + 1);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= W'(1);
    end else if (en && cnt_reg != W'(MAX_WAIT)) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign expired = (cnt_reg == W'(MAX_WAIT));
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, EX branch flushes,
// and memory-wait freezes with timeout halt. Define HAZARD_PERF_EN to add perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = DEF_REG_AW,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic           clk,
  input  logic           rst,
  hazard_ctrl_if.slave   hz
);
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_WAIT = MEM_WAIT;
  localparam logic [1:0] S_HALT = HALT;

  logic [1:0] state_reg, state_next;
  logic       mem_timeout_reg;
  logic       tmr_clr, tmr_load, tmr_en, tmr_expired;
  logic       timeout_set, freeze, halted, load_use;
  logic       pc_wr, if_id_wr, if_id_flush, id_ex_wr, id_ex_flush, ex_mem_wr, mem_wb_flush;

  assign load_use = hz.ex_mem_read && (hz.ex_rd != REG_AW'(REG_ZERO)) &&
                    ((hz.id_use_rs1 && hz.ex_rd == hz.id_rs1) ||
                     (hz.id_use_rs2 && hz.ex_rd == hz.id_rs2));

  hz_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .load    (tmr_load),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_next  = state_reg;
    tmr_clr     = 1'b0;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;
    timeout_set = 1'b0;
    freeze      = 1'b0;
    halted      = 1'b0;
    case (state_reg)
      S_RUN: begin
        if (hz.mem_req && !hz.mem_ready) begin
          freeze     = 1'b1;
          state_next = S_WAIT;
          tmr_load   = 1'b1;
        end
      end
      S_WAIT: begin
        if (!hz.mem_ready) begin
          freeze = 1'b1;
          if (tmr_expired) begin
            state_next  = S_HALT;
            timeout_set = 1'b1;
          end else begin
            tmr_en = 1'b1;
          end
        end else begin
          // Release cycle: the held EX/ID contents are decoded normally below.
          state_next = S_RUN;
          tmr_clr    = 1'b1;
        end
      end
      default: halted = 1'b1;
    endcase
  end

  always_comb begin
    pc_wr        = 1'b1;
    if_id_wr     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_wr     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_wr    = 1'b1;
    mem_wb_flush = 1'b0;
    if (freeze || halted) begin
      pc_wr        = 1'b0;
      if_id_wr     = 1'b0;
      id_ex_wr     = 1'b0;
      ex_mem_wr    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (hz.ex_branch_taken) begin
      // Branch wins over load-use: the flush discards the dependent instruction anyway.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_wr       = 1'b0;
      if_id_wr    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_RUN;
      mem_timeout_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (timeout_set) mem_timeout_reg <= 1'b1;
    end
  end

  assign hz.pc_wr        = pc_wr;
  assign hz.if_id_wr     = if_id_wr;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_wr     = id_ex_wr;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.ex_mem_wr    = ex_mem_wr;
  assign hz.mem_wb_flush = mem_wb_flush;
  assign hz.mem_timeout  = mem_timeout_reg;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cycles_reg, flush_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_reg <= '0;
      flush_count_reg  <= '0;
    end else begin
      if (!pc_wr && state_reg != S_HALT) stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
      if (if_id_flush || id_ex_flush)    flush_count_reg  <= flush_count_reg + CNT_W'(1);
    end
  end

  assign hz.stall_cycles = stall_cycles_reg;
  assign hz.flush_count  = flush_count_reg;
`else
  assign hz.stall_cycles = {CNT_W{1'b0}};
  assign hz.flush_count  = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl against a cycle-level reference model.
// Counter expectations follow HAZARD_PERF_EN (zero when undefined).
module tb_hazard_ctrl;
  localparam int MAX_WAIT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) hz ();

  hazard_ctrl #(.REG_AW(5), .MAX_WAIT(MAX_WAIT), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Model state: 0 = running, 1 = waiting on memory, 2 = halted.
  int          m_mode  = 0;
  int          m_waits = 0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Control vector order: pc_wr if_id_wr if_id_flush id_ex_wr id_ex_flush ex_mem_wr mem_wb_flush mem_timeout
  localparam logic [7:0] C_NORMAL = 8'b1101_0100;
  localparam logic [7:0] C_BRANCH = 8'b1111_1100;
  localparam logic [7:0] C_LOAD   = 8'b0001_1100;
  localparam logic [7:0] C_FREEZE = 8'b0000_0010;
  localparam logic [7:0] C_HALT   = 8'b0000_0011;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] observed();
    return {hz.pc_wr, hz.if_id_wr, hz.if_id_flush, hz.id_ex_wr, hz.id_ex_flush,
            hz.ex_mem_wr, hz.mem_wb_flush, hz.mem_timeout};
  endfunction

  function automatic logic [7:0] model_ctrl(input logic [4:0] rs1, rs2, input logic u1, u2,
                                            input logic [4:0] rd, input logic mr, bt, req, rdy);
    bit lu;
    lu = mr && rd != 0 && ((u1 && rd == rs1) || (u2 && rd == rs2));
    if (m_mode == 2) return C_HALT;
    if ((m_mode == 0 && req && !rdy) || (m_mode == 1 && !rdy)) return C_FREEZE;
    if (bt) return C_BRANCH;
    if (lu) return C_LOAD;
    return C_NORMAL;
  endfunction

  task automatic model_update(input logic [7:0] c, input logic req, rdy);
    if (PERF) begin
      if (!c[7] && m_mode != 2) m_stall = m_stall + 1;
      if (c[5] || c[3])         m_flush = m_flush + 1;
    end
    if (m_mode == 0) begin
      if (req && !rdy) begin m_mode = 1; m_waits = 1; end
    end else if (m_mode == 1) begin
      if (rdy)                       m_mode = 0;
      else if (m_waits == MAX_WAIT)  m_mode = 2;
      else                           m_waits++;
    end
  endtask

  task automatic step(input logic [4:0] rs1, rs2, input logic u1, u2, input logic [4:0] rd,
                      input logic mr, bt, req, rdy);
    logic [7:0] exp;
    @(negedge clk);
    hz.id_rs1 = rs1; hz.id_rs2 = rs2; hz.id_use_rs1 = u1; hz.id_use_rs2 = u2;
    hz.ex_rd = rd; hz.ex_mem_read = mr; hz.ex_branch_taken = bt;
    hz.mem_req = req; hz.mem_ready = rdy;
    #1;
    exp = model_ctrl(rs1, rs2, u1, u2, rd, mr, bt, req, rdy);
    check("ctrl", {24'b0, observed()}, {24'b0, exp});
    check("stall_cycles", hz.stall_cycles, m_stall);
    check("flush_count", hz.flush_count, m_flush);
    $display("t=%0t mode=%0d req=%b rdy=%b bt=%b ctrl=%b stall=%0d flush=%0d",
             $time, m_mode, req, rdy, bt, observed(), hz.stall_cycles, hz.flush_count);
    model_update(exp, req, rdy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset asserted between clock edges; outputs must decode RUN immediately.
  task automatic pulse_reset();
    @(negedge clk);
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0;
    hz.ex_rd = '0; hz.ex_mem_read = 1'b0; hz.ex_branch_taken = 1'b0;
    hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    m_mode = 0; m_waits = 0; m_stall = '0; m_flush = '0;
    check("rst_ctrl", {24'b0, observed()}, {24'b0, C_NORMAL});
    check("rst_stall", hz.stall_cycles, 32'd0);
    check("rst_flush", hz.flush_count, 32'd0);
    $display("t=%0t reset pulse ctrl=%b", $time, observed());
    #1 rst = 1'b0;
  endtask

  initial begin
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0;
    hz.ex_rd = '0; hz.ex_mem_read = 1'b0; hz.ex_branch_taken = 1'b0;
    hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    idle(2);

    // Reset taken while frozen on memory.
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_reset();

    // Load-use on rs2: exactly one bubble, then the load has moved on.
    step(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    // x0 destination never causes a stall.
    step(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Branch together with load-use: branch wins.
    step(5'd5, 5'd3, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    // Zero-wait access: no freeze.
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Three freeze cycles then release.
    pulse_reset();
    for (int i = 0; i < 3; i++) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1);
    if (PERF) check("t4_stall3", hz.stall_cycles, 32'd3);

    // Branch held in frozen EX is acted on in the release cycle.
    pulse_reset();
    for (int i = 0; i < 2; i++) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(1);
    if (PERF) check("t6_flush1", hz.flush_count, 32'd1);

    // Memory never ready: one RUN freeze plus MAX_WAIT wait cycles, then halt.
    pulse_reset();
    for (int i = 0; i < MAX_WAIT + 1; i++)
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step(5'd1, 5'd1, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("halt_timeout", {31'b0, hz.mem_timeout}, 32'd1);
    pulse_reset();
    idle(1);

    // Randomized traffic with occasional stuck memory and resets out of halt.
    begin
      int stuck = 0;
      int halt_cycles = 0;
      for (int n = 0; n < 2000; n++) begin
        logic [4:0] rs1, rs2, rd;
        logic u1, u2, mr, bt, req, rdy;
        rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
        rd  = 5'($urandom_range(0, 3));
        u1  = 1'($urandom); u2 = 1'($urandom);
        mr  = 1'($urandom_range(0, 2) == 0);
        bt  = 1'($urandom_range(0, 5) == 0);
        req = 1'($urandom_range(0, 2) == 0);
        if (stuck == 0 && $urandom_range(0, 120) == 0) stuck = 20;
        if (stuck > 0) begin rdy = 1'b0; stuck--; end
        else rdy = 1'($urandom_range(0, 4) < 3);
        step(rs1, rs2, u1, u2, rd, mr, bt, req, rdy);
        halt_cycles = (m_mode == 2) ? halt_cycles + 1 : 0;
        if (halt_cycles > 3 || $urandom_range(0, 300) == 0) begin
          pulse_reset();
          halt_cycles = 0;
          stuck = 0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
